// File: rtl/mod_pkg.sv
// Shared types and defaults for the modulo issue stage.
// Holds the FSM state enum, width and timeout defaults (MOD_TIMEOUT_EN user).
package mod_pkg;

    localparam int MOD_WIDTH           = 32;
    localparam int MOD_TIMEOUT_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } mod_state_t;

endpackage

// File: rtl/mod_issue.sv
// Issue/handshake stage ahead of the modulo datapath: latches a request,
// bypasses b==0 and a<b locally, starts the datapath, holds the result.
// Ports: clk, reset (async, active-low); in_valid/in_ready/in_a/in_b request;
// dp_a/dp_b/dp_start/dp_done/dp_result datapath; out_valid/out_ready/
// out_result/out_dz/out_timeout response. Macro MOD_TIMEOUT_EN bounds WAIT.
module mod_issue
    import mod_pkg::*;
#(
    parameter int WIDTH          = MOD_WIDTH,
    parameter int TIMEOUT_CYCLES = MOD_TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] dp_a,
    output logic [WIDTH-1:0] dp_b,
    output logic             dp_start,
    input  logic             dp_done,
    input  logic [WIDTH-1:0] dp_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_dz,
    output logic             out_timeout
);

    mod_state_t       state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    logic             dz;
    logic             expire;

    // Reset is folded in so in_ready stays low while reset is held,
    // even though the state register already reads IDLE.
    assign in_ready   = (state == IDLE) && reset;
    assign out_valid  = (state == HOLD);
    assign dp_start   = (state == ISSUE);
    assign dp_a       = op_a;
    assign dp_b       = op_b;
    assign out_result = res;
    assign out_dz     = dz;

`ifdef MOD_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;
    logic          to_q;

    // cnt counts completed WAIT cycles; expiry on the last allowed one.
    assign expire      = (state == WAIT) && (cnt == CW'(TIMEOUT_CYCLES - 1));
    assign out_timeout = to_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (state != WAIT) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_q <= 1'b0;
        end else if (state == WAIT && expire && !dp_done) begin
            to_q <= 1'b1;
        end else if (state == HOLD && out_ready) begin
            to_q <= 1'b0;
        end
    end
`else
    assign expire      = 1'b0;
    assign out_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            dz    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a <= in_a;
                        op_b <= in_b;
                        if (in_b == '0) begin
                            res   <= in_a;
                            dz    <= 1'b1;
                            state <= HOLD;
                        end else if (in_a < in_b) begin
                            res   <= in_a;
                            state <= HOLD;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    // done beats a simultaneous expiry
                    if (dp_done) begin
                        res   <= dp_result;
                        state <= HOLD;
                    end else if (expire) begin
                        res   <= '0;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        dz    <= 1'b0;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod_issue.sv
// Self-checking bench for mod_issue: directed table, hand sequences and
// randomized requests against a behavioural modulo/latency model.
module tb_mod_issue;

`ifdef MOD_TIMEOUT_EN
    localparam int TO    = 4;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TO    = 64;
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] dp_a;
    logic [31:0] dp_b;
    logic        dp_start;
    logic        dp_done;
    logic [31:0] dp_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_dz;
    logic        out_timeout;

    int vecs = 0;
    int errs = 0;

    mod_issue #(.WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .dp_a       (dp_a),
        .dp_b       (dp_b),
        .dp_start   (dp_start),
        .dp_done    (dp_done),
        .dp_result  (dp_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_dz     (out_dz),
        .out_timeout(out_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          k;
        int          hold;
        logic [31:0] res;
        bit          dz;
        int          lat;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full request; k<=0 means the datapath never answers.
    task automatic do_req(input logic [31:0] a, input logic [31:0] b,
                          input int k, input int hold,
                          input logic [31:0] eres, input bit edz,
                          input int elat);
        int  cyc;
        int  st_cyc;
        int  starts;
        int  lat;
        int  n;
        bit  bad;
        bit  bad2;
        bit  byp;
        bit  eto;
        byp = (b == 0) || (a < b);
        eto = 1'b0;
        if (TO_EN && !byp && (k <= 0 || k > TO)) begin
            eres = '0;
            eto  = 1'b1;
            elat = TO + 2;
        end
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("in_ready_pre", in_ready, 1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        tick();
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        cyc    = 1;
        st_cyc = 0;
        starts = 0;
        lat    = 0;
        bad    = 1'b0;
        while (cyc < 200) begin
            if (dp_start) begin
                starts++;
                if (st_cyc == 0) st_cyc = cyc;
            end
            if (out_valid) begin
                lat = cyc;
                break;
            end
            if (in_ready) bad = 1'b1;
            if (!byp && (dp_a !== a || dp_b !== b)) bad = 1'b1;
            dp_done   = (k > 0 && st_cyc > 0 && cyc == st_cyc + k);
            dp_result = dp_done ? a % b : $urandom;
            tick();
            cyc++;
        end
        dp_done = 1'b0;
        chk("latency", lat, elat);
        chk("start_count", starts, byp ? 0 : 1);
        chk("start_cycle", st_cyc, byp ? 0 : 1);
        chk("busy_stable", bad, 0);
        chk("result", out_result, eres);
        chk("dz", out_dz, edz);
        chk("timeout", out_timeout, eto);
        if (hold > 0) begin
            bad2 = 1'b0;
            for (int i = 0; i < hold; i++) begin
                if (out_valid !== 1'b1 || out_result !== eres ||
                    out_dz !== edz || out_timeout !== eto ||
                    in_ready !== 1'b0)
                    bad2 = 1'b1;
                dp_done   = (i == 2);
                dp_result = $urandom;
                tick();
            end
            dp_done = 1'b0;
            chk("hold_stable", bad2, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("post_in_ready", in_ready, 1);
        chk("post_out_valid", out_valid, 0);
        chk("post_flags", {out_dz, out_timeout}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int          rk;
        int          pick;
        bit          rbyp;

        tbl[0] = '{32'd100, 32'd7, 5, 0, 32'd2, 1'b0, 7};
        tbl[1] = '{32'h1234, 32'd0, 3, 0, 32'h1234, 1'b1, 1};
        tbl[2] = '{32'd3, 32'd9, 3, 0, 32'd3, 1'b0, 1};
        tbl[3] = '{32'd100, 32'd7, 2, 10, 32'd2, 1'b0, 4};
        tbl[4] = '{32'd9, 32'd9, 1, 0, 32'd0, 1'b0, 3};
        tbl[5] = '{32'd0, 32'd0, 1, 2, 32'd0, 1'b1, 1};
        tbl[6] = '{32'hFFFFFFFF, 32'd1, 3, 0, 32'd0, 1'b0, 5};
        tbl[7] = '{32'd8, 32'd9, 1, 10, 32'd8, 1'b0, 1};

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        dp_done   = 1'b0;
        dp_result = '0;
        out_ready = 1'b0;
        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_dp_start", dp_start, 0);
        chk("rst_flags", {out_dz, out_timeout}, 0);
        chk("rst_data", {dp_a, dp_b, out_result}, 0);
        tick();
        reset = 1'b1;
        #1;
        chk("rel_in_ready", in_ready, 1);

        // done pulse while idle must be ignored
        dp_done   = 1'b1;
        dp_result = 32'hDEAD;
        tick();
        dp_done = 1'b0;
        chk("idle_done_ignored", {out_valid, in_ready}, 2'b01);

        for (int i = 0; i < 8; i++)
            do_req(tbl[i].a, tbl[i].b, tbl[i].k, tbl[i].hold,
                   tbl[i].res, tbl[i].dz, tbl[i].lat);

        // reset during WAIT aborts everything
        in_valid = 1'b1;
        in_a     = 32'd1000;
        in_b     = 32'd3;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        reset = 1'b0;
        #1;
        chk("wait_rst_out_valid", out_valid, 0);
        chk("wait_rst_in_ready", in_ready, 0);
        chk("wait_rst_data", {dp_a, dp_b, out_result}, 0);
        tick();
        reset = 1'b1;
        #1;
        chk("wait_rst_idle", in_ready, 1);
        tick();
        do_req(32'd50, 32'd8, 3, 0, 32'd2, 1'b0, 5);

        // reset during ISSUE drops dp_start asynchronously
        in_valid = 1'b1;
        in_a     = 32'd77;
        in_b     = 32'd5;
        tick();
        in_valid = 1'b0;
        chk("issue_start", dp_start, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("issue_rst_start", dp_start, 0);
        tick();
        reset = 1'b1;
        tick();

`ifdef MOD_TIMEOUT_EN
        // never answers: timeout at t+TO+2, late done ignored in hold
        do_req(32'd20, 32'd3, 0, 6, 32'd0, 1'b0, TO + 2);
        // done on the expiry edge wins
        do_req(32'd20, 32'd3, TO, 0, 32'd2, 1'b0, TO + 2);
`endif

        for (int i = 0; i < 40; i++) begin
            ra   = $urandom;
            pick = $urandom_range(0, 3);
            case (pick)
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 16);
                2: begin
                    ra = ra >> 8;
                    rb = ra + $urandom_range(0, 100);
                end
                default: rb = $urandom;
            endcase
            rk   = $urandom_range(1, 8);
            rbyp = (rb == 0) || (ra < rb);
            do_req(ra, rb, rk, $urandom_range(0, 3),
                   (rb == 0) ? ra : ra % rb, rb == 0,
                   rbyp ? 1 : rk + 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
